// File: rtl/party_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : party_io_pkg
//  Description : Shared types and helpers for the party board I/O blocks.
//                - key_state_t : per-key hold-tracking state
//                - key_cnt_width() : width of a counter that must reach the
//                  given value without wrapping
//  Revision    : 1.0  initial release
// ============================================================================
package party_io_pkg;

    // Per-channel hold state: released, pressed (counting towards long),
    // held (long-press reached, auto-repeating).
    typedef enum logic [1:0] {
        KEY_IDLE    = 2'd0,
        KEY_PRESSED = 2'd1,
        KEY_HELD    = 2'd2
    } key_state_t;

    // Bits needed to hold 0..count. A zero or negative count still yields a
    // one-bit counter so that disabled features elaborate cleanly.
    function automatic int key_cnt_width(input int count);
        return (count < 1) ? 1 : $clog2(count + 1);
    endfunction

endpackage : party_io_pkg
`default_nettype wire

// File: rtl/party_key_channel.sv
`default_nettype none
// ============================================================================
//  Module      : party_key_channel
//  Description : One pushbutton channel: 2-FF synchroniser, polarity
//                normalisation, counter debounce, press/release pulses,
//                long-press detection, auto-repeat and a sticky pending bit.
//  Ports       : clk, rst          clock, asynchronous active-high reset
//                i_key_raw         raw key pin (asynchronous)
//                i_enable          0 suppresses event pulses / pending sets
//                i_ack             clears the pending bit
//                o_level           debounced state, 1 = pressed
//                o_press/o_release 1-cycle pulses on debounced edges
//                o_long            1-cycle pulse when hold reaches LONG_CYCLES
//                o_repeat          1-cycle auto-repeat pulse while held
//                o_pending         sticky, set by press/repeat, cleared by ack
//  Revision    : 1.0  initial release
// ============================================================================
module party_key_channel
    import party_io_pkg::*;
#(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_raw,
    input  logic i_enable,
    input  logic i_ack,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat,
    output logic o_pending
);

    localparam int c_DEB_W  = key_cnt_width(DEBOUNCE_CYCLES);
    localparam int c_HOLD_W = key_cnt_width(LONG_CYCLES);
    localparam int c_REP_W  = key_cnt_width(REPEAT_CYCLES);

    localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DEB_W-1:0]  c_DEB_ONE   = c_DEB_W'(1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(LONG_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
    localparam logic [c_REP_W-1:0]  c_REP_LAST  = c_REP_W'(REPEAT_CYCLES - 1);
    localparam logic [c_REP_W-1:0]  c_REP_ONE   = c_REP_W'(1);

    logic                r_sync1;
    logic                r_sync2;
    logic                r_level;
    logic [c_DEB_W-1:0]  r_deb_cnt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_REP_W-1:0]  r_rep_cnt;
    key_state_t          r_state;
    logic                r_press;
    logic                r_release;
    logic                r_long;
    logic                r_repeat;
    logic                r_pending;

    logic w_s;
    logic w_differ;
    logic w_flip;
    logic w_rise;
    logic w_fall;

    // Normalised synchronised sample: 1 = pressed regardless of pin polarity.
    assign w_s      = r_sync2 ^ ACTIVE_LOW;
    assign w_differ = (w_s != r_level);
    // The debounced level flips on the edge where the counter has seen
    // DEBOUNCE_CYCLES-1 earlier differing samples and the current one still differs.
    assign w_flip   = w_differ && (r_deb_cnt == c_DEB_LAST);
    assign w_rise   = w_flip &  w_s;
    assign w_fall   = w_flip & ~w_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Sync FFs hold the released pin level so nothing fires out of reset.
            r_sync1    <= ACTIVE_LOW;
            r_sync2    <= ACTIVE_LOW;
            r_level    <= 1'b0;
            r_deb_cnt  <= '0;
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
            r_state    <= KEY_IDLE;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
            r_repeat   <= 1'b0;
            r_pending  <= 1'b0;
        end else begin
            r_sync1 <= i_key_raw;
            r_sync2 <= r_sync1;

            if (!w_differ) begin
                r_deb_cnt <= '0;
            end else if (w_flip) begin
                r_level   <= w_s;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + c_DEB_ONE;
            end

            // Pulses coincide with the first cycle of the new level.
            r_press   <= w_rise & i_enable;
            r_release <= w_fall & i_enable;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;

            // A fall overrides every state, so long/repeat never share a
            // cycle with release.
            if (w_fall) begin
                r_state    <= KEY_IDLE;
                r_hold_cnt <= '0;
                r_rep_cnt  <= '0;
            end else begin
                case (r_state)
                    KEY_IDLE: begin
                        if (w_rise) begin
                            r_state    <= KEY_PRESSED;
                            r_hold_cnt <= '0;
                        end
                    end
                    KEY_PRESSED: begin
                        if (r_hold_cnt == c_HOLD_LAST) begin
                            r_state   <= KEY_HELD;
                            r_rep_cnt <= '0;
                            r_long    <= i_enable;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + c_HOLD_ONE;
                        end
                    end
                    KEY_HELD: begin
                        if (REPEAT_CYCLES != 0) begin
                            if (r_rep_cnt == c_REP_LAST) begin
                                r_rep_cnt <= '0;
                                r_repeat  <= i_enable;
                            end else begin
                                r_rep_cnt <= r_rep_cnt + c_REP_ONE;
                            end
                        end
                    end
                    default: begin
                        r_state <= KEY_IDLE;
                    end
                endcase
            end

            // Set comes from the registered (already enable-gated) pulses and
            // is OR-ed after the ack mask, so a coincident ack cannot lose it.
            r_pending <= (r_pending & ~i_ack) | r_press | r_repeat;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;
    assign o_repeat  = r_repeat;
    assign o_pending = r_pending;

endmodule : party_key_channel
`default_nettype wire

// File: rtl/party_key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : party_key_conditioner
//  Description : N-channel pushbutton conditioner between the board KEY pins
//                and the PIO / game logic. Each bit is an independent
//                party_key_channel.
//  Ports       : clk_clk      system clock
//                reset_reset  asynchronous active-high reset
//                key_raw_i    raw key pins
//                enable_i     0 suppresses event pulses / pending sets
//                ack_i        per-bit pending clear mask
//                level_o      debounced state (1 = pressed)
//                press_o, release_o, long_o, repeat_o  1-cycle event pulses
//                pending_o    sticky event flags
//  Revision    : 1.0  initial release
// ============================================================================
module party_key_conditioner
    import party_io_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [N_KEYS-1:0] key_raw_i,
    input  logic              enable_i,
    input  logic [N_KEYS-1:0] ack_i,
    output logic [N_KEYS-1:0] level_o,
    output logic [N_KEYS-1:0] press_o,
    output logic [N_KEYS-1:0] release_o,
    output logic [N_KEYS-1:0] long_o,
    output logic [N_KEYS-1:0] repeat_o,
    output logic [N_KEYS-1:0] pending_o
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_channel
        party_key_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW != 0),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_channel (
            .clk       (clk_clk),
            .rst       (reset_reset),
            .i_key_raw (key_raw_i[g]),
            .i_enable  (enable_i),
            .i_ack     (ack_i[g]),
            .o_level   (level_o[g]),
            .o_press   (press_o[g]),
            .o_release (release_o[g]),
            .o_long    (long_o[g]),
            .o_repeat  (repeat_o[g]),
            .o_pending (pending_o[g])
        );
    end

endmodule : party_key_conditioner
`default_nettype wire

// File: tb/tb_party_key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_party_key_conditioner
//  Description : Directed self-checking bench for party_key_conditioner
//                (4 keys, active-low pins, debounce 4, long 20, repeat 5).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_party_key_conditioner;

    localparam int c_N = 4;

    logic           clk;
    logic           rst;
    logic [c_N-1:0] key_raw;
    logic           enable;
    logic [c_N-1:0] ack;
    logic [c_N-1:0] level_o, press_o, release_o, long_o, repeat_o, pending_o;

    party_key_conditioner #(
        .N_KEYS          (c_N),
        .ACTIVE_LOW      (1),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .REPEAT_CYCLES   (5)
    ) u_dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .key_raw_i   (key_raw),
        .enable_i    (enable),
        .ack_i       (ack),
        .level_o     (level_o),
        .press_o     (press_o),
        .release_o   (release_o),
        .long_o      (long_o),
        .repeat_o    (repeat_o),
        .pending_o   (pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Event monitor, updated once per cycle by tick().
    int press_n [c_N];
    int press_at[c_N];
    int rel_n   [c_N];
    int rel_at  [c_N];
    int long_n  [c_N];
    int long_at [c_N];
    int rep_n   [c_N];
    int rep_first[c_N];
    int rep_last[c_N];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    task automatic clr_mon();
        for (int i = 0; i < c_N; i++) begin
            press_n[i] = 0; press_at[i] = -1;
            rel_n[i]   = 0; rel_at[i]   = -1;
            long_n[i]  = 0; long_at[i]  = -1;
            rep_n[i]   = 0; rep_first[i] = -1; rep_last[i] = -1;
        end
    endtask

    // Advance one clock; sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < c_N; i++) begin
            if (press_o[i])   begin press_n[i]++; press_at[i] = cyc; end
            if (release_o[i]) begin rel_n[i]++;   rel_at[i]   = cyc; end
            if (long_o[i])    begin long_n[i]++;  long_at[i]  = cyc; end
            if (repeat_o[i])  begin
                if (rep_n[i] == 0) rep_first[i] = cyc;
                rep_n[i]++;
                rep_last[i] = cyc;
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic ack_all();
        ack = '1;
        tick();
        ack = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int t0;
    int e0;
    int r0;

    initial begin
        rst     = 1'b1;
        key_raw = '1;
        enable  = 1'b1;
        ack     = '0;
        clr_mon();
        run(3);
        check_eq("reset_outputs", {level_o, press_o, release_o, long_o, repeat_o, pending_o}, 32'd0);
        rst = 1'b0;
        run(10);
        check_eq("idle_level", level_o, 0);
        check_eq("idle_pending", pending_o, 0);

        // 1: clean press on key 0, level/press exactly 6 cycles after pin edge.
        clr_mon();
        t0 = cyc;
        key_raw[0] = 1'b0;
        run(5);
        check_eq("t1_level_before", level_o[0], 0);
        check_eq("t1_press_before", press_o[0], 0);
        tick();
        check_eq("t1_level_at6", level_o[0], 1);
        check_eq("t1_press_at6", press_o[0], 1);
        check_eq("t1_press_cycle", press_at[0], t0 + 6);
        tick();
        check_eq("t1_press_one_cycle", press_o[0], 0);
        check_eq("t1_pending_set", pending_o, 4'b0001);
        run(3);
        check_eq("t1_pending_sticky", pending_o[0], 1);
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        check_eq("t1_pending_acked", pending_o[0], 0);
        key_raw[0] = 1'b1;
        run(10);
        check_eq("t1_release_count", rel_n[0], 1);
        check_eq("t1_level_released", level_o[0], 0);

        // 2: 3-cycle glitch rejected, then bounce 0/1/0 + stable -> one press.
        clr_mon();
        key_raw[1] = 1'b0;
        run(3);
        key_raw[1] = 1'b1;
        run(12);
        check_eq("t2_glitch_press", press_n[1], 0);
        check_eq("t2_glitch_level", level_o[1], 0);
        key_raw[1] = 1'b0;
        tick();
        key_raw[1] = 1'b1;
        tick();
        t0 = cyc;
        key_raw[1] = 1'b0;
        run(12);
        check_eq("t2_bounce_press_count", press_n[1], 1);
        check_eq("t2_bounce_press_cycle", press_at[1], t0 + 6);
        key_raw[1] = 1'b1;
        run(10);
        ack_all();

        // 3: long press and auto-repeat on key 2, released before the 5th repeat.
        clr_mon();
        t0 = cyc;
        key_raw[2] = 1'b0;
        run(6);
        e0 = cyc;
        check_eq("t3_press", press_o[2], 1);
        run(39);
        key_raw[2] = 1'b1;
        run(15);
        check_eq("t3_long_count", long_n[2], 1);
        check_eq("t3_long_cycle", long_at[2], e0 + 20);
        check_eq("t3_repeat_count", rep_n[2], 4);
        check_eq("t3_repeat_first", rep_first[2], e0 + 25);
        check_eq("t3_repeat_last", rep_last[2], e0 + 40);
        check_eq("t3_release_count", rel_n[2], 1);
        check_eq("t3_release_cycle", rel_at[2], e0 + 45);
        check_eq("t3_pending", pending_o[2], 1);
        ack_all();
        check_eq("t3_pending_acked", pending_o, 0);

        // 4: ack coincident with press -> set wins; ack next cycle clears.
        clr_mon();
        key_raw[3] = 1'b0;
        run(6);
        check_eq("t4_press", press_o[3], 1);
        ack[3] = 1'b1;
        tick();
        check_eq("t4_set_wins", pending_o[3], 1);
        tick();
        ack[3] = 1'b0;
        check_eq("t4_ack_clears", pending_o[3], 0);
        key_raw[3] = 1'b1;
        run(10);

        // 5: enable low during press of key 0.
        clr_mon();
        enable = 1'b0;
        key_raw[0] = 1'b0;
        run(8);
        check_eq("t5_level", level_o[0], 1);
        check_eq("t5_press_count", press_n[0], 0);
        check_eq("t5_pending", pending_o[0], 0);
        enable = 1'b1;
        run(3);
        check_eq("t5_no_replay", press_n[0], 0);
        key_raw[0] = 1'b1;
        run(10);
        ack_all();

        // 6: reset while key 2 is HELD, then all four keys together.
        clr_mon();
        key_raw[2] = 1'b0;
        run(6 + 25);
        check_eq("t6_held_level", level_o[2], 1);
        check_eq("t6_held_pending", pending_o[2], 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_async_level", level_o, 0);
        check_eq("t6_async_pending", pending_o, 0);
        run(2);
        rst = 1'b0;
        r0 = cyc;
        clr_mon();
        run(5);
        check_eq("t6_no_early_press", press_n[2], 0);
        tick();
        check_eq("t6_press_after_reset", press_o[2], 1);
        check_eq("t6_press_cycle", press_at[2], r0 + 6);
        key_raw[2] = 1'b1;
        run(10);
        ack_all();

        clr_mon();
        key_raw = '0;
        run(6);
        check_eq("t6_all_press", press_o, 4'hF);
        check_eq("t6_all_level", level_o, 4'hF);
        key_raw = '1;
        run(6);
        check_eq("t6_all_release", release_o, 4'hF);
        run(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_party_key_conditioner
`default_nettype wire
